promedio_sched: RTL
===================

Name: promedio_sched

Overview:
- Round-robin scheduler that shares one 4-sample averaging datapath (`promedio`, N=8) between NCH sample-producing channels.
- Per request it:
  - picks a channel and steers that channel's samples onto the datapath input;
  - sequences the datapath's `en`/`sum_en` controls and waits for `sum_ready`;
  - captures the average and returns it tagged with the channel number.
- Sits between the sensor front-ends and the `promedio` instance.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- N, 8, average/result width; must match the datapath's N.
- TIMEOUT, 16, maximum ACCUM cycles allowed before abort (must be >= 8).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- ctrl_en  in  1  global enable; low forces IDLE.
- req  in  NCH  per-channel average request (level).
- ch_data  in  16*NCH  per-channel sample bus; channel k occupies bits [16k+15:16k].
- grant  out  NCH  one-hot; high while channel k's samples are consumed.
- avg_en  out  1  drives datapath `en`.
- avg_sum_en  out  1  drives datapath `sum_en`.
- avg_in  out  16  drives datapath `in`.
- avg_sum_ready  in  1  from datapath `sum_ready`.
- avg_out  in  N  from datapath `out`.
- result  out  N  captured average.
- result_ch  out  clog2(NCH)  channel the result belongs to.
- result_valid  out  1  one-cycle pulse.
- err  out  1  one-cycle pulse on timeout.
- err_ch  out  clog2(NCH)  channel that timed out.

Behaviour:

Reset (asynchronous, active-high):
- State = IDLE; rr_ptr = 0; cur_ch = 0.
- grant, avg_en, avg_sum_en, result, result_ch, result_valid, err, err_ch all reset to 0.

State machine (IDLE, ACCUM, LATCH, DONE, ABORT):
- IDLE:
  - avg_en = avg_sum_en = 0.
  - If ctrl_en = 1 and req != 0: pick the first set req bit scanning from rr_ptr upward, with wrap.
  - Latch that channel into cur_ch, set grant one-hot, clear timer, go to ACCUM.
- ACCUM:
  - avg_en = avg_sum_en = 1; avg_in = ch_data[cur_ch] (combinational, live); timer increments.
  - If avg_sum_ready = 1, go to LATCH. With the datapath timing this is the 6th ACCUM cycle.
  - Samples consumed are ch_data[cur_ch] during ACCUM cycles 1-4. The requester must present them on those cycles.
  - Else if timer = TIMEOUT-1, go to ABORT.
- LATCH:
  - avg_en = 1, avg_sum_en = 0, which clears the datapath counter and sum.
  - grant drops at entry.
  - avg_out is valid in this cycle; result <= avg_out and result_ch <= cur_ch at the end of the cycle. Go to DONE.
- DONE:
  - result_valid = 1 for exactly this cycle.
  - rr_ptr <= cur_ch+1 (mod NCH). Go to IDLE.
- ABORT:
  - avg_en = avg_sum_en = 0; grant = 0.
  - err = 1 and err_ch = cur_ch for this cycle; result is unchanged.
  - rr_ptr <= cur_ch+1. Go to IDLE.

Latency and rules:
- result_valid is asserted 8 cycles after the first ACCUM cycle; that cycle counts as cycle 1.
- avg_sum_en is low for at least 2 cycles between transactions (LATCH/DONE, or ABORT/IDLE), so the datapath always starts from contador = 0.
- req is sampled only in IDLE. Deasserting req mid-transaction is ignored; the transaction completes.
- ctrl_en = 0 in ACCUM or LATCH: next state IDLE, outputs as IDLE, grant = 0. No result_valid, no err, rr_ptr unchanged.
- A single requesting channel holding req high is re-granted on the IDLE cycle following DONE.
- All channels requesting: strict rotation 0, 1, 2, 3, 0, ...
- A request arriving during a transaction waits; it is not lost as long as req is held.
- result is not arithmetic in this block; it is avg_out verbatim. The datapath truncates its sum to N bits.

Decomposition:
- promedio_pkg holds:
  - the state enumeration (IDLE, ACCUM, LATCH, DONE, ABORT);
  - the sample width constant SAMPLE_W = 16;
  - the sample count constant SAMPLES = 4.
- One sub-module, rr_arbiter: combinational; takes req and rr_ptr, returns a one-hot grant and an index. It is instantiated once.

Test Plan:
- Single channel: req=4'b0010; channel 1 presents 10, 20, 30, 40 on ACCUM cycles 1-4. Expect grant=4'b0010 for 6 cycles, then result=25, result_ch=1, result_valid pulse 8 cycles after grant rises.
- Round-robin: req=4'b1111 held; every channel presents constant 8. Expect result_ch sequence 0, 1, 2, 3, 0 with result=8 each, grants never overlapping, avg_sum_en low for at least 2 cycles between grants.
- Timeout: TIMEOUT=16; avg_sum_ready tied 0; req=4'b0100. Expect err pulse with err_ch=2 after 16 ACCUM cycles, no result_valid, next grant starts searching at channel 3.
- Mid-operation abort: ctrl_en dropped in ACCUM cycle 3. Expect grant=0 and avg_en=0 the next cycle, no result_valid, no err, rr_ptr unchanged, so the same channel is granted again when ctrl_en returns.
- Async reset: reset asserted in LATCH between clock edges. Expect all outputs 0 immediately; after release, a req=4'b0001 transaction completes normally with result matching its samples.
- req withdrawn: req[3] deasserted in ACCUM cycle 2. Expect the transaction to complete with result_ch=3.

Source files
------------

// File: rtl/promedio_pkg.sv
// Shared definitions for the promedio scheduler.
//   state_e  : scheduler FSM states
//   SAMPLE_W : width of one channel sample / datapath input
//   SAMPLES  : number of samples averaged by the datapath per transaction
package promedio_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    LATCH = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  localparam int SAMPLE_W = 16;
  localparam int SAMPLES  = 4;

endpackage

// File: rtl/promedio_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req    : per-channel request vector
//   rr_ptr : channel with highest priority this round
//   grant  : one-hot of the chosen channel (all zero when nothing requests)
//   idx    : binary index of the chosen channel
//   valid  : at least one request present
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  rr_ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  idx,
  output logic           valid
);

  int pos;

  // Walk offsets from farthest to nearest so the channel closest to rr_ptr
  // (going upward with wrap) is the last writer and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      pos = int'(rr_ptr) + i;
      if (pos >= NCH) pos = pos - NCH;
      if (req[pos[CW-1:0]]) begin
        grant                = '0;
        grant[pos[CW-1:0]]   = 1'b1;
        idx                  = pos[CW-1:0];
        valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/promedio_sched.sv
// Round-robin scheduler sharing one 4-sample averaging datapath among NCH
// channels. Picks a requester, steers its samples onto the datapath, waits
// for sum_ready, captures the average and returns it tagged with the channel.
//   clk, reset        : clock, asynchronous active-high reset
//   ctrl_en           : global enable; low aborts any transaction silently
//   req               : per-channel request level
//   ch_data           : per-channel 16-bit samples, channel k at [16k+15:16k]
//   grant             : one-hot, high while the channel's samples are consumed
//   avg_en/avg_sum_en : datapath controls, avg_in : datapath sample input
//   avg_sum_ready     : datapath sum ready, avg_out : datapath average
//   result/result_ch  : captured average and its channel
//   result_valid      : one-cycle pulse when result is new
//   err/err_ch        : one-cycle pulse and channel on accumulate timeout
module promedio_sched
  import promedio_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ctrl_en,
  input  logic [NCH-1:0]            req,
  input  logic [SAMPLE_W*NCH-1:0]   ch_data,
  output logic [NCH-1:0]            grant,
  output logic                      avg_en,
  output logic                      avg_sum_en,
  output logic [SAMPLE_W-1:0]       avg_in,
  input  logic                      avg_sum_ready,
  input  logic [N-1:0]              avg_out,
  output logic [N-1:0]              result,
  output logic [$clog2(NCH)-1:0]    result_ch,
  output logic                      result_valid,
  output logic                      err,
  output logic [$clog2(NCH)-1:0]    err_ch
);

  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic [CW-1:0]   result_ch_q, result_ch_d;
  logic [N-1:0]    result_q, result_d;
  logic [NCH-1:0]  grant_q, grant_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [NCH-1:0]  arb_grant;
  logic [CW-1:0]   arb_idx;
  logic            arb_valid;
  logic [CW-1:0]   next_ptr;

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  // Live mux: the requester must hold the right sample on each ACCUM cycle.
  assign avg_in    = ch_data[cur_ch_q*SAMPLE_W +: SAMPLE_W];
  assign next_ptr  = (cur_ch_q == CW'(NCH - 1)) ? '0 : cur_ch_q + CW'(1);
  // Dropping ctrl_en makes outputs look like IDLE immediately.
  assign grant     = ctrl_en ? grant_q : '0;
  assign result    = result_q;
  assign result_ch = result_ch_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_ch_d     = cur_ch_q;
    result_d     = result_q;
    result_ch_d  = result_ch_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    avg_en       = 1'b0;
    avg_sum_en   = 1'b0;
    result_valid = 1'b0;
    err          = 1'b0;
    err_ch       = '0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (ctrl_en && arb_valid) begin
          cur_ch_d = arb_idx;
          grant_d  = arb_grant;
          timer_d  = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (!ctrl_en) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          avg_en     = 1'b1;
          avg_sum_en = 1'b1;
          timer_d    = timer_q + TW'(1);
          if (avg_sum_ready) begin
            grant_d = '0;
            state_d = LATCH;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            grant_d = '0;
            state_d = ABORT;
          end
        end
      end
      LATCH: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else begin
          // en with sum_en low clears the datapath while out is still valid.
          avg_en      = 1'b1;
          result_d    = avg_out;
          result_ch_d = cur_ch_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        rr_ptr_d     = next_ptr;
        state_d      = IDLE;
      end
      ABORT: begin
        err      = 1'b1;
        err_ch   = cur_ch_q;
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_ch_q    <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      grant_q     <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_ch_q    <= cur_ch_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
    end
  end

endmodule
